// File: rtl/root_calc_pkg.sv
// Shared definitions for the root calculator's terminal output path.
// Holds the formatter FSM states, the selector for which kind of byte is
// being sent (hex digit, CR or LF), and the ASCII constants used to build
// the printable line.
package root_calc_pkg;

  // Formatter FSM states
  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    WAIT_RTS,
    WAIT_ACK
  } state_e;

  // Which part of the line is currently being sent
  typedef enum logic [1:0] {
    SEL_DIGIT,
    SEL_CR,
    SEL_LF
  } sel_e;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational hex digit encoder.
// Ports:
//   nibble - 4-bit value 0..15
//   ascii  - printable code: '0'-'9', then 'A'-'F' or 'a'-'f' by UPPERCASE
module nibble_to_ascii
  import root_calc_pkg::*;
#(
  parameter int UPPERCASE = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Letters are offset from the chosen 'A'/'a' base by (n - 10)
  always_comb begin
    ascii = ASCII_0 + {4'h0, nibble};
    if (nibble > 4'd9) begin
      if (UPPERCASE != 0) begin
        ascii = ASCII_A_UP + {4'h0, nibble} - 8'd10;
      end else begin
        ascii = ASCII_A_LO + {4'h0, nibble} - 8'd10;
      end
    end
  end

endmodule

// File: rtl/sqrt_hex_formatter.sv
// Turns a square-root result word into an ASCII hex line ("00001F3A\r\n")
// and streams it byte by byte to the RS232 transmitter, paced by rts.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   in_data         - result word, captured on in_data_ready while idle
//   in_data_ready   - one-cycle pulse marking in_data valid
//   data_request    - transmitter rts level, high = ready for a byte
//   out_data        - ASCII byte, held until the next out_data_ready
//   out_data_ready  - one-cycle pulse marking out_data valid
//   busy            - high from capture until the last byte is acknowledged
//   overrun         - sticky flag: a word arrived while busy
module sqrt_hex_formatter
  import root_calc_pkg::*;
#(
  parameter int NIBBLES        = 8,
  parameter int UPPERCASE      = 1,
  parameter int SUPPRESS_ZEROS = 0,
  parameter int APPEND_CRLF    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic                   in_data_ready,
  input  logic                   data_request,
  output logic [7:0]             out_data,
  output logic                   out_data_ready,
  output logic                   busy,
  output logic                   overrun
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 3);
  localparam logic [CW-1:0] CNT_FULL = CW'(NIBBLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e          state_q, state_d;
  sel_e            sel_q, sel_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  logic [3:0]      top_nibble;
  logic [7:0]      digit_ascii;
  logic [7:0]      cur_byte;
  logic            frame_done;

  assign top_nibble = shift_q[W-1 -: 4];

  nibble_to_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_nibble_to_ascii (
    .nibble(top_nibble),
    .ascii (digit_ascii)
  );

  // Byte that would be issued now, given which part of the line we are in
  always_comb begin
    cur_byte = digit_ascii;
    case (sel_q)
      SEL_CR:  cur_byte = ASCII_CR;
      SEL_LF:  cur_byte = ASCII_LF;
      default: cur_byte = digit_ascii;
    endcase
  end

  // Next-state and output logic. cnt_q counts digits still to send,
  // including the one currently at the top of the shift register.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    frame_done  = 1'b0;

    // A word arriving mid-frame (including the final acknowledge cycle)
    // is dropped and only flagged.
    if (in_data_ready && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_data_ready) begin
          shift_d = in_data;
          cnt_d   = CNT_FULL;
          sel_d   = SEL_DIGIT;
          busy_d  = 1'b1;
          state_d = (SUPPRESS_ZEROS != 0) ? SKIP : WAIT_RTS;
        end
      end

      SKIP: begin
        if (top_nibble == 4'h0 && cnt_q > CNT_ONE) begin
          shift_d = {shift_q[W-5:0], 4'h0};
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          // Done skipping: act as WAIT_RTS this cycle so that skipping
          // costs exactly one cycle per dropped zero.
          state_d = WAIT_RTS;
          if (data_request) begin
            out_data_d  = cur_byte;
            out_valid_d = 1'b1;
            state_d     = WAIT_ACK;
          end
        end
      end

      WAIT_RTS: begin
        if (data_request) begin
          out_data_d  = cur_byte;
          out_valid_d = 1'b1;
          state_d     = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // rts low means the transmitter took the byte
        if (!data_request) begin
          state_d = WAIT_RTS;
          case (sel_q)
            SEL_DIGIT: begin
              if (cnt_q > CNT_ONE) begin
                shift_d = {shift_q[W-5:0], 4'h0};
                cnt_d   = cnt_q - CNT_ONE;
              end else if (APPEND_CRLF != 0) begin
                sel_d = SEL_CR;
              end else begin
                frame_done = 1'b1;
              end
            end
            SEL_CR:  sel_d = SEL_LF;
            default: frame_done = 1'b1;
          endcase
          if (frame_done) begin
            state_d = IDLE;
            sel_d   = SEL_DIGIT;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= SEL_DIGIT;
      shift_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_data_ready = out_valid_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule
